f_cmp_arbiter: RTL and testbench
================================

# f_cmp_arbiter

Round-robin arbiter and two-stage pipeline that shares one `f_less_or_equal` comparator among `N_REQ` requesters. Each requester presents a double-precision operand pair with a valid/ready handshake. The block tags each accepted pair with its requester index and returns `a <= b` plus the comparator invalid flag on a single valid/ready result channel. It sits between the scalar issue ports of the FP datapath and the shared comparison resource.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag. Derived; do not override.
- Operand width is `FLEN` from `config.vh` (64). Format is fixed to double.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_vld`  in  N_REQ  per-requester operand valid.
- `req_rdy`  out  N_REQ  per-requester accept. One-hot or zero.
- `req_a`  in  N_REQ*FLEN  packed operand a; requester i occupies `[i*FLEN +: FLEN]`.
- `req_b`  in  N_REQ*FLEN  packed operand b; same packing as `req_a`.
- `res_vld`  out  1  result valid.
- `res_rdy`  in  1  result consumer ready.
- `res_id`  out  ID_W  index of the requester that owns the result.
- `res`  out  1  result of `a <= b`.
- `res_err`  out  1  comparator invalid flag (`CmpNV`).

## Operation
- **Transfer rules**
  - Request transfer for requester i: `req_vld[i] && req_rdy[i]` at a rising edge.
  - Result transfer: `res_vld && res_rdy`.
  - Once `req_vld[i]` is asserted, it and the operands stay stable until transferred.
  - `req_vld` must not depend combinationally on `req_rdy`.
- **Arbitration**
  - Rotating priority pointer `ptr` (ID_W bits).
  - The candidate is the first `i` with `req_vld[i]=1`, scanning `ptr, ptr+1, …` modulo N_REQ. Wrap is correct for non-power-of-2 N_REQ.
  - `req_rdy[candidate] = s1_free`. All other `req_rdy` bits are 0.
  - `ptr <= candidate+1` (mod N_REQ), only on a request transfer. Otherwise `ptr` holds.
- **Stage S1 (operand register)**
  - Registers `s1_vld`, `s1_a`, `s1_b`, `s1_id`.
  - Feeds `f_less_or_equal` combinationally.
  - `s1_free = !s1_vld || s1_adv`.
- **Stage S2 (result register)**
  - Registers `res_vld`, `res`, `res_err`, `res_id`.
  - `s1_adv = s1_vld && (!res_vld || res_rdy)`.
  - On `s1_adv`, S2 loads the comparator outputs and `s1_id`, and sets `res_vld=1`.
  - If `res_rdy` arrives with no `s1_adv`, `res_vld` drops to 0.
- **Per-stage state:** EMPTY / FULL via the valid bits. S1 can refill in the same cycle it drains, so back-to-back operation gives full throughput.
- **Comparator semantics**
  - Any operand with exponent all-ones (NaN or infinity) forces `res_err=1` and `res=0`.
  - `+0` and `-0` compare equal.
- **Reset**
  - `ptr=0`, `s1_vld=0`, `res_vld=0`, `res=0`, `res_err=0`, `res_id=0`.
  - `req_rdy` is forced to 0 while `rst=1`.
  - Reset mid-operation discards in-flight S1/S2 contents with no result emitted.
- Data registers (`s1_a`, `s1_b`) do not need reset.

## Timing
- **Latency:** a request accepted at edge T produces `res_vld=1` after edge T+1. Two registers from input to output.
- **Throughput:** one comparison per cycle when `res_rdy=1` continuously.
- **Backpressure**
  - With `res_rdy=0` and S2 full: S1 holds, and S1 accepts at most one more request.
  - After that, all `req_rdy=0` until S2 drains.
  - Result outputs are stable while `res_vld && !res_rdy`.
- **Simultaneous events**
  - Result drain and a new S1 advance in the same cycle: S2 reloads, `res_vld` stays 1.
  - S1 advance and a new request in the same cycle: S1 reloads.
- `req_rdy` is combinational from `req_vld`, `ptr`, `s1_vld`, `res_vld`, `res_rdy`. All other outputs are registered.

## Test plan
- **Reset:** reset, then all `req_vld=0` -> `res_vld=0`, `req_rdy=0`, `ptr=0`. Assert `rst` with S1/S2 full -> next cycle `res_vld=0`, and no stale result appears afterwards.
- **Single request:** requester 2 sends a=`0x3FF0000000000000` (1.0), b=`0x4000000000000000` (2.0) -> 2 cycles later `res=1`, `res_err=0`, `res_id=2`. Swapping a and b gives `res=0`.
- **Special values:**
  - a=`0x8000000000000000`, b=0 -> `res=1`.
  - a=`0x7FF8000000000000` -> `res_err=1`, `res=0`.
  - b=`0x7FF0000000000000` -> `res_err=1`.
- **Round-robin fairness:** all 4 requesters hold `req_vld=1` for 8 cycles with `res_rdy=1` -> grant order 0,1,2,3,0,1,2,3, one `res_vld` per cycle, and `res_id` sequence matches.
- **Backpressure:** `res_rdy=0` for 5 cycles during continuous requests -> exactly 2 accepts, then `req_rdy=0`, outputs stable. On `res_rdy=1` -> results arrive in accept order with no loss or duplication.
- **Wrap and odd N:** `N_REQ=3`, requesters 0 and 2 active, `ptr` starts at 2 -> grants alternate 2,0,2,0.

Source files
------------

// File: rtl/f_cmp_arbiter.sv
// Round-robin front end sharing one double-precision a<=b comparator among
// N_REQ requesters through an operand register (S1) and a result register (S2).

module f_less_or_equal (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le,
  output logic        nv
);
  logic a_special;
  logic b_special;
  logic both_zero;
  logic mag_le;
  logic mag_ge;

  always_comb begin
    a_special = &a[62:52];
    b_special = &b[62:52];
    both_zero = (a[62:0] == 63'd0) && (b[62:0] == 63'd0);
    mag_le    = a[62:0] <= b[62:0];
    mag_ge    = a[62:0] >= b[62:0];
    nv        = a_special || b_special;
    // Sign-magnitude ordering: magnitude order flips when both are negative.
    if (nv)                  le = 1'b0;
    else if (both_zero)      le = 1'b1;
    else if (a[63] != b[63]) le = a[63];
    else if (a[63])          le = mag_ge;
    else                     le = mag_le;
  end
endmodule

module f_cmp_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int ID_W  = $clog2(N_REQ),
  localparam int FLEN  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic [N_REQ*FLEN-1:0]   req_a,
  input  logic [N_REQ*FLEN-1:0]   req_b,
  output logic                    res_vld,
  input  logic                    res_rdy,
  output logic [ID_W-1:0]         res_id,
  output logic                    res,
  output logic                    res_err
);
  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // a producer holds valid and data stable until then, and never derives valid
  // from ready. req_rdy is the only combinational output.

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] nxt_ptr;
  logic            found;
  logic            acc;
  logic [FLEN-1:0] cand_a;
  logic [FLEN-1:0] cand_b;

  logic            s1_vld;
  logic [FLEN-1:0] s1_a;
  logic [FLEN-1:0] s1_b;
  logic [ID_W-1:0] s1_id;
  logic            s1_adv;
  logic            s1_free;

  logic            cmp_le;
  logic            cmp_nv;
  int              idx;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        cand  = ID_W'(idx);
      end
    end
  end

  assign s1_adv  = s1_vld && (!res_vld || res_rdy);
  assign s1_free = !s1_vld || s1_adv;

  always_comb begin
    req_rdy = '0;
    if (!rst && found && s1_free) req_rdy[cand] = 1'b1;
  end

  assign acc     = |(req_vld & req_rdy);
  assign nxt_ptr = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + ID_W'(1);
  assign cand_a  = req_a[int'(cand)*FLEN +: FLEN];
  assign cand_b  = req_b[int'(cand)*FLEN +: FLEN];

  f_less_or_equal u_cmp (
    .a  (s1_a),
    .b  (s1_b),
    .le (cmp_le),
    .nv (cmp_nv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      s1_vld  <= 1'b0;
      s1_id   <= '0;
      res_vld <= 1'b0;
      res     <= 1'b0;
      res_err <= 1'b0;
      res_id  <= '0;
    end else begin
      // S1 refills in the same cycle it hands its operands to S2.
      if (acc) begin
        ptr    <= nxt_ptr;
        s1_vld <= 1'b1;
        s1_id  <= cand;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
      if (s1_adv) begin
        res_vld <= 1'b1;
        res     <= cmp_le;
        res_err <= cmp_nv;
        res_id  <= s1_id;
      end else if (res_rdy) begin
        res_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      s1_a <= cand_a;
      s1_b <= cand_b;
    end
  end
endmodule

// File: tb/tb_f_cmp_arbiter.sv
// Bench for f_cmp_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order and result contents.

module tb_f_cmp_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_vld = '0;
  logic [3:0]   req_rdy;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         res_vld;
  logic         res_rdy = 1'b1;
  logic [1:0]   res_id;
  logic         res;
  logic         res_err;
  logic [63:0]  drv_a [4];
  logic [63:0]  drv_b [4];

  logic [2:0]   vld3 = '0;
  logic [2:0]   rdy3;
  logic [191:0] a3 = '0;
  logic [191:0] b3 = '0;
  logic         res_vld3;
  logic         res_rdy3 = 1'b1;
  logic [1:0]   res_id3;
  logic         res3;
  logic         res_err3;

  int n_cmp = 0;
  int n_bad = 0;

  int         m_ptr = 0;
  bit         m_s1v = 1'b0;
  bit         m_s2v = 1'b0;
  logic [3:0] m_grant = '0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*64 +: 64] = drv_a[i];
      req_b[i*64 +: 64] = drv_b[i];
    end
  end

  f_cmp_arbiter dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_id(res_id), .res(res), .res_err(res_err)
  );

  f_cmp_arbiter #(.N_REQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_vld(vld3), .req_rdy(rdy3),
    .req_a(a3), .req_b(b3), .res_vld(res_vld3), .res_rdy(res_rdy3),
    .res_id(res_id3), .res(res3), .res_err(res_err3)
  );

  // Reference: {res, err} from real-valued comparison; NaN/inf flagged invalid.
  function automatic logic [1:0] ref_cmp(input logic [63:0] a, input logic [63:0] b);
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return 2'b01;
    return {($bitstoreal(a) <= $bitstoreal(b)), 1'b0};
  endfunction

  function automatic int pick(input logic [3:0] vld, input int p);
    for (int k = 0; k < 4; k++)
      if (vld[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [63:0] rand_fp();
    logic [63:0] v;
    case ($urandom_range(0, 9))
      0: v = {1'($urandom_range(0, 1)), 63'd0};
      1: v = 64'h7FF8000000000000;
      2: v = {1'($urandom_range(0, 1)), 11'h7FF, 52'd0};
      3: v = {1'($urandom_range(0, 1)), 11'd0, 20'($urandom), 32'($urandom)};
      default: v = {1'($urandom_range(0, 1)), 11'($urandom_range(1021, 1025)),
                    20'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // Model: two-slot pipeline occupancy, rotating pointer, results in accept order.
  always @(posedge clk) begin
    int   c;
    logic free;
    logic adv;
    logic drain;
    logic [3:0] g;
    if (rst) begin
      m_ptr   <= 0;
      m_s1v   <= 1'b0;
      m_s2v   <= 1'b0;
      m_grant <= '0;
      exp_q.delete();
    end else begin
      c     = pick(req_vld, m_ptr);
      free  = !m_s1v || !m_s2v || res_rdy;
      adv   = m_s1v && (!m_s2v || res_rdy);
      drain = m_s2v && res_rdy;
      g     = '0;
      if (drain) void'(exp_q.pop_front());
      if (adv) m_s2v <= 1'b1;
      else if (drain) m_s2v <= 1'b0;
      if (c >= 0 && free) begin
        g[c] = 1'b1;
        exp_q.push_back({2'(c), ref_cmp(drv_a[c], drv_b[c])});
        m_ptr <= (c + 1) % 4;
        m_s1v <= 1'b1;
      end else if (adv) begin
        m_s1v <= 1'b0;
      end
      m_grant <= g;
    end
  end

  always @(negedge clk) begin
    int         c;
    logic [3:0] er;
    if (!rst) begin
      c  = pick(req_vld, m_ptr);
      er = (c >= 0 && (!m_s1v || !m_s2v || res_rdy)) ? 4'(1 << c) : 4'b0;
      n_cmp++;
      if (req_rdy !== er) begin
        n_bad++;
        $display("FAIL sb_grant t=%0t: req_rdy=%b expected %b", $time, req_rdy, er);
      end
      n_cmp++;
      if (res_vld !== m_s2v) begin
        n_bad++;
        $display("FAIL sb_res_vld t=%0t: res_vld=%b expected %b", $time, res_vld, m_s2v);
      end
      if (m_s2v && exp_q.size() > 0) begin
        n_cmp++;
        if ({res_id, res, res_err} !== exp_q[0]) begin
          n_bad++;
          $display("FAIL sb_result t=%0t: {id,res,err}=%b expected %b", $time,
                   {res_id, res, res_err}, exp_q[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0; vld3 = '0; res_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = 4'hF; res_rdy = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== 4'b0) begin
      n_bad++; $display("FAIL reset_rdy_in_rst: req_rdy=%b expected 0000", req_rdy);
    end
    tick();
    rst = 1'b0; req_vld = '0;
    @(negedge clk);
    n_cmp++;
    if (res_vld !== 1'b0 || req_rdy !== 4'b0) begin
      n_bad++; $display("FAIL reset_idle: res_vld=%b req_rdy=%b expected 0/0000", res_vld, req_rdy);
    end
    tick();
    req_vld = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== 4'b0001) begin
      n_bad++; $display("FAIL reset_ptr0: req_rdy=%b expected 0001", req_rdy);
    end
    tick();
    req_vld = '0;
    repeat (3) tick();
  endtask

  task automatic test_single();
    logic [63:0] ta [2];
    logic [63:0] tb [2];
    logic        tr [2];
    ta[0] = 64'h3FF0000000000000; tb[0] = 64'h4000000000000000; tr[0] = 1'b1;
    ta[1] = 64'h4000000000000000; tb[1] = 64'h3FF0000000000000; tr[1] = 1'b0;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      drv_a[2] = ta[t]; drv_b[2] = tb[t]; req_vld = 4'b0100;
      tick();
      req_vld = '0;
      n_cmp++;
      if (res_vld !== 1'b0) begin
        n_bad++; $display("FAIL single_latency%0d: res_vld=%b expected 0 one edge after accept", t, res_vld);
      end
      tick();
      n_cmp++;
      if ({res_vld, res, res_err, res_id} !== {1'b1, tr[t], 1'b0, 2'd2}) begin
        n_bad++;
        $display("FAIL single%0d: vld/res/err/id=%b%b%b/%0d expected 1%b0/2", t,
                 res_vld, res, res_err, res_id, tr[t]);
      end
      tick();
    end
  endtask

  task automatic test_special();
    logic [63:0] ta [6];
    logic [63:0] tb [6];
    logic [1:0]  te [6];
    ta[0] = 64'h8000000000000000; tb[0] = 64'h0000000000000000; te[0] = 2'b10;
    ta[1] = 64'h0000000000000000; tb[1] = 64'h8000000000000000; te[1] = 2'b10;
    ta[2] = 64'h7FF8000000000000; tb[2] = 64'h3FF0000000000000; te[2] = 2'b01;
    ta[3] = 64'h3FF0000000000000; tb[3] = 64'h7FF0000000000000; te[3] = 2'b01;
    ta[4] = 64'hBFF0000000000000; tb[4] = 64'hC000000000000000; te[4] = 2'b00;
    ta[5] = 64'h0000000000000001; tb[5] = 64'h0000000000000001; te[5] = 2'b10;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      drv_a[1] = ta[t]; drv_b[1] = tb[t]; req_vld = 4'b0010;
      tick();
      req_vld = '0;
      tick();
      n_cmp++;
      if ({res_vld, res, res_err, res_id} !== {1'b1, te[t], 2'd1}) begin
        n_bad++;
        $display("FAIL special%0d: vld/res/err/id=%b%b%b/%0d expected 1%b/1", t,
                 res_vld, res, res_err, res_id, te[t]);
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv_a[i] = rand_fp(); drv_b[i] = rand_fp();
    end
    req_vld = 4'hF; res_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) begin
        n_cmp++;
        if (req_rdy !== 4'(1 << (k % 4))) begin
          n_bad++; $display("FAIL rr_grant%0d: req_rdy=%b expected %b", k, req_rdy, 4'(1 << (k % 4)));
        end
      end
      if (k >= 2) begin
        n_cmp++;
        if (res_vld !== 1'b1 || res_id !== 2'((k - 2) % 4)) begin
          n_bad++; $display("FAIL rr_res%0d: res_vld=%b res_id=%0d expected 1/%0d", k, res_vld, res_id, (k - 2) % 4);
        end
      end
      tick();
      if (k == 7) req_vld = '0;
    end
  endtask

  task automatic test_backpressure();
    int         n_acc;
    logic [3:0] snap;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drv_a[i] = rand_fp(); drv_b[i] = rand_fp();
    end
    n_acc = 0; snap = '0;
    req_vld = 4'hF; res_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (|req_rdy) n_acc++;
      if (k == 2) snap = {res_id, res, res_err};
      if (k > 2) begin
        n_cmp++;
        if ({res_vld, res_id, res, res_err} !== {1'b1, snap}) begin
          n_bad++; $display("FAIL bp_stable%0d: vld,id,res,err=%b expected 1%b", k,
                            {res_vld, res_id, res, res_err}, snap);
        end
      end
      tick();
    end
    n_cmp++;
    if (n_acc !== 2) begin
      n_bad++; $display("FAIL bp_accepts: %0d accepts expected 2", n_acc);
    end
    req_vld = '0; res_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k < 2 && (res_vld !== 1'b1 || res_id !== 2'(k))) begin
        n_bad++; $display("FAIL bp_order%0d: res_vld=%b res_id=%0d expected 1/%0d", k, res_vld, res_id, k);
      end else if (k == 2 && res_vld !== 1'b0) begin
        n_bad++; $display("FAIL bp_nodup: res_vld=%b expected 0", res_vld);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_vld = 4'hF; res_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b1; req_vld = '0;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== 4'b0) begin
      n_bad++; $display("FAIL rstmid_rdy: req_rdy=%b expected 0000", req_rdy);
    end
    tick();
    rst = 1'b0; res_rdy = 1'b1;
    n_cmp++;
    if (res_vld !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_flush: res_vld=%b expected 0", res_vld);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (res_vld !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_stale%0d: res_vld=%b expected 0", k, res_vld);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int n_acc;
    int n_out;
    do_reset();
    n_acc = 0; n_out = 0;
    for (int cyc = 0; cyc < 412; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_vld[i] && m_grant[i]) begin
          req_vld[i] = 1'b0;
          n_acc++;
        end
        if (cyc < 400 && !req_vld[i] && $urandom_range(0, 2) == 0) begin
          drv_a[i] = rand_fp();
          case ($urandom_range(0, 3))
            0:       drv_b[i] = drv_a[i];
            1:       drv_b[i] = {~drv_a[i][63], drv_a[i][62:0]};
            default: drv_b[i] = rand_fp();
          endcase
          req_vld[i] = 1'b1;
        end
      end
      res_rdy = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (res_vld && res_rdy) n_out++;
      tick();
    end
    n_cmp++;
    if (n_out !== n_acc || req_vld !== 4'b0) begin
      n_bad++; $display("FAIL random_count: %0d results for %0d accepts, pending=%b", n_out, n_acc, req_vld);
    end
  endtask

  task automatic test_odd_n();
    logic [2:0] eg [4];
    logic [1:0] eid [4];
    eg[0] = 3'b100; eg[1] = 3'b001; eg[2] = 3'b100; eg[3] = 3'b001;
    eid[1] = 2'd1; eid[2] = 2'd2; eid[3] = 2'd0; eid[0] = 2'd0;
    do_reset();
    res_rdy3 = 1'b1; vld3 = 3'b010;
    @(negedge clk);
    n_cmp++;
    if (rdy3 !== 3'b010) begin
      n_bad++; $display("FAIL odd_setup: rdy3=%b expected 010", rdy3);
    end
    tick();
    vld3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (rdy3 !== eg[k]) begin
        n_bad++; $display("FAIL odd_grant%0d: rdy3=%b expected %b", k, rdy3, eg[k]);
      end
      if (k >= 1) begin
        n_cmp++;
        if (res_vld3 !== 1'b1 || res_id3 !== eid[k]) begin
          n_bad++; $display("FAIL odd_res%0d: res_vld3=%b res_id3=%0d expected 1/%0d", k, res_vld3, res_id3, eid[k]);
        end
      end
      tick();
    end
    vld3 = '0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_special();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_odd_n();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
